// File: rtl/mul_seq_param.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq_param
//  Purpose  : Sequential WIDTH x WIDTH multiplier, one partial-product step
//             per clock. Unsigned shift-add or signed radix-2 Booth, chosen
//             per operation. Product is left in the A:Q register pair.
//  Ports    : clk, rst (async, active high)
//             start       - request a multiply (accepted in IDLE or DONE)
//             signed_mode - 0 unsigned, 1 two's complement (sampled w/ start)
//             eX, Y       - multiplicand / multiplier (sampled w/ start)
//             busy        - high while iterating
//             done        - one-cycle pulse, A:Q hold the product
//             A, Q        - high / low half of the product
//             ovf         - product does not fit in WIDTH bits
//                           (only when MUL_SEQ_PARAM_OVF_EN is defined)
//  Options  : `define MUL_SEQ_PARAM_OVF_EN adds the registered ovf output.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module mul_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] eX,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
`ifdef MUL_SEQ_PARAM_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Q
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic             r_mode;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_a_step;
    logic [WIDTH-1:0] w_q_step;

    assign w_accept = start && (r_state != c_st_run);
    assign w_last   = (r_cnt == c_cnt_one);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run:  if (w_last) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = start ? c_st_run : c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_st_run:  busy = 1'b1;
            c_st_done: done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // One partial-product step.
    // The add is done one bit wider than A. In unsigned mode the extra bit is
    // the carry C that the logical shift moves into A[WIDTH-1]. In Booth mode
    // it is the true sign of A +/- M, so the arithmetic shift stays exact
    // even when A - M overflows WIDTH bits (e.g. min*min).
    // ------------------------------------------------------------------------
    always_comb begin
        w_a_ext = r_mode ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
        w_m_ext = r_mode ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
        w_sum   = w_a_ext;
        if (!r_mode) begin
            if (r_q[0]) begin
                w_sum = w_a_ext + w_m_ext;
            end
        end else begin
            case ({r_q[0], r_q1})
                2'b10:   w_sum = w_a_ext - w_m_ext;
                2'b01:   w_sum = w_a_ext + w_m_ext;
                default: w_sum = w_a_ext;
            endcase
        end
    end

    assign w_a_step = w_sum[WIDTH:1];
    assign w_q_step = {w_sum[0], r_q[WIDTH-1:1]};

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_m    <= '0;
            r_a    <= '0;
            r_q    <= '0;
            r_q1   <= 1'b0;
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= c_cnt_init;
            r_m    <= eX;
            r_a    <= '0;
            r_q    <= Y;
            r_q1   <= 1'b0;
            r_mode <= signed_mode;
        end else if (r_state == c_st_run) begin
            r_cnt  <= r_cnt - c_cnt_one;
            r_a    <= w_a_step;
            r_q    <= w_q_step;
            r_q1   <= r_q[0];
        end
    end

    assign A = r_a;
    assign Q = r_q;

`ifdef MUL_SEQ_PARAM_OVF_EN
    // ------------------------------------------------------------------------
    // Overflow flag, evaluated on the final step so it lands with done.
    // Signed: the high half must be pure sign extension of the low half.
    // ------------------------------------------------------------------------
    logic r_ovf;
    logic w_ovf_nxt;

    assign w_ovf_nxt = r_mode ? (w_a_step != {WIDTH{w_q_step[WIDTH-1]}})
                              : (w_a_step != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == c_st_run) && w_last) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_seq_param
//  Purpose  : Directed self-checking bench for mul_seq_param (WIDTH=8 and
//             WIDTH=16 instances). Expected products are hand computed.
//             Define MUL_SEQ_PARAM_OVF_EN to also exercise the ovf output.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul_seq_param;

    logic        clk;
    logic        rst;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  x8, y8, a8, q8;
    logic        start16, sm16, busy16, done16;
    logic [15:0] x16, y16, a16, q16;
`ifdef MUL_SEQ_PARAM_OVF_EN
    logic        ovf8;
    logic        ovf16;
`endif

    int n_total = 0;
    int n_bad   = 0;

    mul_seq_param #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_mode (sm8),
        .eX          (x8),
        .Y           (y8),
        .busy        (busy8),
        .done        (done8),
`ifdef MUL_SEQ_PARAM_OVF_EN
        .ovf         (ovf8),
`endif
        .A           (a8),
        .Q           (q8)
    );

    mul_seq_param #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .signed_mode (sm16),
        .eX          (x16),
        .Y           (y16),
        .busy        (busy16),
        .done        (done16),
`ifdef MUL_SEQ_PARAM_OVF_EN
        .ovf         (ovf16),
`endif
        .A           (a16),
        .Q           (q16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation with start pulsed for a single cycle.
    task automatic mul8(input string tag, input logic sm, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp, input logic exp_ovf);
        int n;
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; x8 = x; y8 = y;
        @(negedge clk);
        start8 = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom); sm8 = ~sm;
        chk({tag, "_busy"}, 64'(busy8), 64'd1);
`ifdef MUL_SEQ_PARAM_OVF_EN
        chk({tag, "_ovfclr"}, 64'(ovf8), 64'd0);
`endif
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd8);
        chk({tag, "_prod"}, 64'({a8, q8}), 64'(exp));
`ifdef MUL_SEQ_PARAM_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf8), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unexpected X ovf expectation");
`endif
        @(negedge clk);
        chk({tag, "_pulse"}, 64'({done8, busy8}), 64'd0);
        chk({tag, "_hold"}, 64'({a8, q8}), 64'(exp));
    endtask

    initial begin
        int last, ndone, n;
        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
        start16 = 1'b0; sm16 = 1'b0; x16 = '0; y16 = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", 64'({busy8, done8, a8, q8}), 64'd0);
        rst = 1'b0;

        // Basic and edge products
        mul8("u3x2",    1'b0, 8'd3,   8'd2,   16'h0006, 1'b0);
        mul8("u255sq",  1'b0, 8'hFF,  8'hFF,  16'hFE01, 1'b1);
        mul8("sm3x2",   1'b1, 8'hFD,  8'h02,  16'hFFFA, 1'b0);
        mul8("u16x16",  1'b0, 8'd16,  8'd16,  16'h0100, 1'b1);
        mul8("sm1sq",   1'b1, 8'hFF,  8'hFF,  16'h0001, 1'b0);
        mul8("sminsq",  1'b1, 8'h80,  8'h80,  16'h4000, 1'b1);
        mul8("s5xm7",   1'b1, 8'h05,  8'hF9,  16'hFFDD, 1'b0);

        // start held high: back-to-back ops every WIDTH+1 cycles
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; x8 = 8'd5; y8 = 8'd7;
        last = -1; ndone = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (done8) begin
                chk("held_prod", 64'({a8, q8}), 64'h0023);
                if (last >= 0) chk("held_period", 64'(i - last), 64'd9);
                last = i; ndone++;
                x8 = 8'd5; y8 = 8'd7; sm8 = 1'b0;
            end else begin
                x8 = 8'($urandom); y8 = 8'($urandom); sm8 = 1'($urandom);
            end
        end
        chk("held_count", 64'(ndone), 64'd3);
        start8 = 1'b0;
        n = 0;
        while ((busy8 || done8) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("held_idle", 64'(busy8), 64'd0);

        // Reset in the middle of a run
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; x8 = 8'd9; y8 = 8'd11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_clr", 64'({busy8, done8, a8, q8}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("midrst_nodone", 64'(ndone), 64'd0);
        mul8("after_rst", 1'b0, 8'd9, 8'd11, 16'h0063, 1'b0);

        // WIDTH=16 signed min * max
        @(negedge clk);
        start16 = 1'b1; sm16 = 1'b1; x16 = 16'h8000; y16 = 16'h7FFF;
        @(negedge clk);
        start16 = 1'b0; x16 = 16'h1234; y16 = 16'h5678;
        n = 0;
        while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("w16_lat", 64'(n), 64'd16);
        chk("w16_prod", 64'({a16, q16}), 64'hC0008000);
`ifdef MUL_SEQ_PARAM_OVF_EN
        chk("w16_ovf", 64'(ovf16), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
